// File: rtl/seq_pkg.sv
// Shared definitions for the programmable sequence detector family.
// Holds the default sizing constants and the control-state encoding so
// that the detector and any checker bound to it agree on what the state
// bit means.
package seq_pkg;

  // Default sizing: longest pattern, width of the length field (must be
  // able to hold DEF_MAX_LEN) and width of the match counter.
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 8;

  // Control-state encoding. IDLE means "no usable configuration", RUN
  // means a legal pattern length is loaded and detection is live.
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (count -> 0)
//   inc  - add one this edge, unless already at all-ones
//   clr  - force count to 0 this edge; wins over inc
//   q    - current count
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector.
// A pattern of 1..MAX_LEN bits, its length and the overlap mode are loaded
// with cfg_load; enabled xin samples are shifted into a history register
// and compared against the pattern. A match produces a one-cycle
// registered pulse on out and bumps a saturating match counter.
//
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-low reset
//   cfg_load     - latch cfg_pattern/cfg_len/cfg_overlap this edge
//                  (takes priority over en; that edge's xin is dropped)
//   cfg_pattern  - pattern, bit [len-1] is received first, bit [0] last
//   cfg_len      - pattern length in bits, legal range 1..MAX_LEN
//   cfg_overlap  - 1: matches may share bits, 0: each match needs fresh bits
//   en, xin      - sample xin on this edge when en is high
//   clr_cnt      - synchronous clear of match_cnt (wins over a hit)
//   out          - one-cycle match pulse, registered
//   match_cnt    - saturating count of matches
//   cfg_err      - loaded length is illegal, detection disabled; this is
//                  also the visible control state (1 = IDLE, 0 = RUN)
//
// Handshake note: there is no backpressure. en is a qualifier only; a
// sample is consumed on every rising edge where en=1, cfg_load=0 and the
// block is in RUN. Cycles with en=0 are invisible to the pattern.
module seq_detect_prog
  import seq_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               en,
  input  logic               xin,
  input  logic               clr_cnt,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               out_q, out_d;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] len_mask;
  logic               shift_en;
  logic               cfg_len_ok;
  logic               hit;

  // Candidate values for a shift edge, plus the compare against the
  // low len bits of the pattern. fill saturates at MAX_LEN: once the
  // history is full every further sample keeps it full.
  always_comb begin
    shift_en   = en && !cfg_load && (state_q == S_RUN);
    cfg_len_ok = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
    hist_n     = {hist_q[MAX_LEN-2:0], xin};
    fill_n     = (fill_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                             : fill_q + LEN_W'(1);
    len_mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hit = shift_en && (fill_n >= len_q) &&
          (((hist_n ^ pat_q) & len_mask) == '0);
  end

  // Next-state logic for configuration, control state and the shifter.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    out_d   = 1'b0;

    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = cfg_len_ok ? S_RUN : S_IDLE;
    end else if (shift_en) begin
      hist_d = hist_n;
      out_d  = hit;
      // Non-overlapping mode forgets the matched bits so the next match
      // must be built entirely from new samples.
      fill_d = (hit && !ovl_q) ? '0 : fill_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (clr_cnt),
    .q   (match_cnt)
  );

  assign out     = out_q;
  assign cfg_err = (state_q == S_IDLE);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog. Two instances share every input: one with
// the default 8-bit counter and one with a 2-bit counter so saturation is
// reached quickly. A behavioural model keeps the list of enabled samples
// since the last configuration (or last non-overlapping match) and
// decides matches by reading the newest len samples as a number.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               en;
  logic               xin;
  logic               clr_cnt;
  logic               out_a, err_a, out_b, err_b;
  logic [7:0]         cnt_a;
  logic [1:0]         cnt_b;

  int n_checks;
  int n_errors;

  // Reference model state.
  int m_pat, m_len, m_err, m_out, m_cnt_a, m_cnt_b;
  bit m_ovl;
  bit bits_q[$];

  seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .xin(xin),
    .clr_cnt(clr_cnt), .out(out_a), .match_cnt(cnt_a), .cfg_err(err_a)
  );

  seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .xin(xin),
    .clr_cnt(clr_cnt), .out(out_b), .match_cnt(cnt_b), .cfg_err(err_b)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_match();
    int v;
    int n;
    n = bits_q.size();
    if (n < m_len) return 1'b0;
    v = 0;
    for (int i = 0; i < m_len; i++) v = v * 2 + int'(bits_q[n - m_len + i]);
    return v == (m_pat % (1 << m_len));
  endfunction

  task automatic model_reset();
    m_pat = 0; m_len = 0; m_ovl = 1'b0; m_err = 1; m_out = 0;
    m_cnt_a = 0; m_cnt_b = 0;
    bits_q.delete();
  endtask

  task automatic model_edge();
    bit hit;
    hit = 1'b0;
    if (cfg_load) begin
      m_pat = int'(cfg_pattern);
      m_len = int'(cfg_len);
      m_ovl = cfg_overlap;
      m_err = (m_len == 0 || m_len > MAX_LEN) ? 1 : 0;
      m_out = 0;
      bits_q.delete();
    end else if (en && m_err == 0) begin
      bits_q.push_back(xin);
      if (bits_q.size() > MAX_LEN) void'(bits_q.pop_front());
      hit = model_match();
      m_out = hit ? 1 : 0;
      if (hit && !m_ovl) bits_q.delete();
    end else begin
      m_out = 0;
    end
    if (clr_cnt) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else if (hit) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3)   m_cnt_b++;
    end
  endtask

  task automatic check_all();
    chk("out_a", int'(out_a), m_out);
    chk("cnt_a", int'(cnt_a), m_cnt_a);
    chk("err_a", int'(err_a), m_err);
    chk("out_b", int'(out_b), m_out);
    chk("cnt_b", int'(cnt_b), m_cnt_b);
    chk("err_b", int'(err_b), m_err);
  endtask

  // Driver tasks: inputs change 1 time unit after an edge, outputs are
  // checked 1 time unit after the following edge.
  task automatic step(input bit ld, input int pat, input int len, input bit ovl,
                      input bit e, input bit x, input bit clr);
    cfg_load    = ld;
    cfg_pattern = MAX_LEN'(pat);
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    en          = e;
    xin         = x;
    clr_cnt     = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic load(input int pat, input int len, input bit ovl);
    step(1'b1, pat, len, ovl, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic bit_in(input bit x);
    step(1'b0, 0, 0, 1'b0, 1'b1, x, 1'b0);
  endtask

  task automatic idle_cycle();
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    int r;
    int len;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; en = 1'b0; xin = 1'b0; clr_cnt = 1'b0;
    model_reset();
    #3;
    chk("rst_out", int'(out_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_err", int'(err_a), 1);
    #9;
    rst = 1'b1;

    // Unconfigured: ones do nothing.
    for (int i = 0; i < 4; i++) bit_in(1'b1);

    // 11000, len 5, non-overlapping.
    load(5'b11000, 5, 1'b0);
    bit_in(1); bit_in(1); bit_in(0); bit_in(0);
    chk("t1_pre", int'(out_a), 0);
    bit_in(0);
    chk("t1_out", int'(out_a), 1);
    chk("t1_cnt", int'(cnt_a), 1);
    bit_in(0);
    chk("t1_drop", int'(out_a), 0);

    // 101 overlapping, then non-overlapping, same stream 1,0,1,0,1.
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    load(3'b101, 3, 1'b1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    chk("t2_ovl_cnt", int'(cnt_a), 2);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    load(3'b101, 3, 1'b0);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    chk("t2_novl_cnt", int'(cnt_a), 1);

    // en gaps are transparent.
    load(5'b11000, 5, 1'b0);
    bit_in(1); bit_in(1);
    idle_cycle(); idle_cycle(); idle_cycle();
    bit_in(0); bit_in(0); bit_in(0);
    chk("t3_out", int'(out_a), 1);

    // Illegal lengths.
    load(8'hff, 0, 1'b1);
    chk("t4_err0", int'(err_a), 1);
    for (int i = 0; i < 10; i++) bit_in(1'b1);
    load(8'hff, MAX_LEN + 1, 1'b1);
    chk("t4_err9", int'(err_a), 1);
    for (int i = 0; i < 10; i++) bit_in(1'b1);
    load(1, 1, 1'b1);
    chk("t4_reload", int'(err_a), 0);

    // len 1 overlapping: saturation of both counters, clear vs hit.
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) bit_in(1'b1);
    chk("t5_sat_b", int'(cnt_b), 3);
    for (int i = 0; i < 255; i++) bit_in(1'b1);
    chk("t5_sat_a", int'(cnt_a), 255);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_clr_out", int'(out_a), 1);
    chk("t5_clr_cnt", int'(cnt_b), 0);

    // Reset in the middle of a pattern.
    load(5'b11000, 5, 1'b0);
    bit_in(1); bit_in(1); bit_in(0); bit_in(0);
    async_reset();
    chk("t6_err", int'(err_a), 1);
    load(5'b11000, 5, 1'b0);
    bit_in(0);
    chk("t6_nomatch", int'(out_a), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        len = ($urandom_range(0, 99) < 75) ? $urandom_range(1, 4)
                                           : $urandom_range(0, 12);
        load($urandom_range(0, 255), len, 1'($urandom_range(0, 1)));
      end else if (r < 4) begin
        @(negedge clk);
        async_reset();
      end else begin
        step(1'b0, 0, 0, 1'b0, $urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
